// File: rtl/p_hardisc.sv
// Shared definitions for the hardisc AHB timer: register map, CTRL fields, response states.
package p_hardisc;

  localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_CTRL        = 5'h10;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    RESP_OKAY,
    RESP_ERR1,
    RESP_ERR2
  } resp_state_t;

  function automatic logic tmr_addr_mapped(input logic [4:0] addr);
    return (addr == TMR_MTIME_LO)    || (addr == TMR_MTIME_HI) ||
           (addr == TMR_MTIMECMP_LO) || (addr == TMR_MTIMECMP_HI) ||
           (addr == TMR_CTRL);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 64-bit free-running MTIME counter advanced by a programmable prescaler.
module timer_counter #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_clr_presc,
  input  logic               i_wr_lo,
  input  logic               i_wr_hi,
  input  logic [31:0]        i_wdata,
  output logic [63:0]        o_mtime
);

  logic [PRESC_W-1:0] r_presc_cnt;
  logic [63:0]        r_mtime;
  logic               w_tick;
  logic [63:0]        w_mtime_inc;

  assign w_tick      = i_en && (r_presc_cnt == i_presc);
  assign w_mtime_inc = r_mtime + 64'd1;
  assign o_mtime     = r_mtime;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc_cnt <= '0;
      r_mtime     <= '0;
    end else begin
      if (i_clr_presc) begin
        r_presc_cnt <= '0;
      end else if (i_en) begin
        r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
      end
      // A bus write drops a coincident tick; the untouched half keeps its old value.
      if (i_wr_lo || i_wr_hi) begin
        if (i_wr_lo) r_mtime[31:0]  <= i_wdata;
        if (i_wr_hi) r_mtime[63:32] <= i_wdata;
      end else if (w_tick) begin
        r_mtime <= w_mtime_inc;
      end
    end
  end

endmodule

// File: rtl/ahb_timer.sv
// AHB3-Lite slave exposing a RISC-V style MTIME/MTIMECMP timer with machine timer interrupt.
module ahb_timer
  import p_hardisc::*;
#(
  parameter int unsigned PRESC_W = 8
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic [4:0]  s_haddr_i,
  input  logic [31:0] s_hwdata_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic        s_hsel_i,
  input  logic [2:0]  s_hburst_i,
  input  logic [3:0]  s_hprot_i,
  input  logic        s_hmastlock_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hready_o,
  output logic        s_hresp_o,
  output logic        s_int_mtip_o
);

  resp_state_t        r_state;
  logic               r_hready;
  logic               r_hresp;
  logic               r_mtip;
  logic               r_dp_valid;
  logic               r_dp_write;
  logic [4:0]         r_dp_addr;
  logic [63:0]        r_mtimecmp;
  logic               r_ctrl_en;
  logic [PRESC_W-1:0] r_ctrl_presc;

  logic [63:0]        w_mtime;
  logic               w_accept;
  logic               w_req_ok;
  logic               w_wr_commit;
  logic               w_wr_ctrl;
  logic               w_wr_mtime_lo;
  logic               w_wr_mtime_hi;
  logic [31:0]        w_ctrl_rd;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_accept      = s_hsel_i & s_htrans_i[1] & r_hready;
  assign w_req_ok      = (s_hsize_i == HSIZE_WORD) && tmr_addr_mapped(s_haddr_i);
  assign w_wr_commit   = r_dp_valid & r_dp_write;
  assign w_wr_ctrl     = w_wr_commit && (r_dp_addr == TMR_CTRL);
  assign w_wr_mtime_lo = w_wr_commit && (r_dp_addr == TMR_MTIME_LO);
  assign w_wr_mtime_hi = w_wr_commit && (r_dp_addr == TMR_MTIME_HI);
  assign w_unused      = ^{s_htrans_i[0], s_hburst_i, s_hprot_i, s_hmastlock_i};

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_state  <= RESP_OKAY;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      case (r_state)
        RESP_ERR1: begin
          r_state  <= RESP_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          if (w_accept && !w_req_ok) begin
            r_state  <= RESP_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= 1'b1;
          end else begin
            r_state  <= RESP_OKAY;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Validity is resolved in the address phase so a bad access never reaches the data phase.
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_valid <= w_accept & w_req_ok;
      if (w_accept) begin
        r_dp_write <= s_hwrite_i;
        r_dp_addr  <= s_haddr_i;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_mtimecmp   <= '1;
      r_ctrl_en    <= 1'b0;
      r_ctrl_presc <= '0;
      r_mtip       <= 1'b0;
    end else begin
      if (w_wr_commit) begin
        case (r_dp_addr)
          TMR_MTIMECMP_LO: r_mtimecmp[31:0]  <= s_hwdata_i;
          TMR_MTIMECMP_HI: r_mtimecmp[63:32] <= s_hwdata_i;
          TMR_CTRL: begin
            r_ctrl_en    <= s_hwdata_i[CTRL_EN_BIT];
            r_ctrl_presc <= s_hwdata_i[CTRL_PRESC_LSB +: PRESC_W];
          end
          default: ;
        endcase
      end
      r_mtip <= (w_mtime >= r_mtimecmp);
    end
  end

  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[CTRL_EN_BIT] = r_ctrl_en;
    w_ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = r_ctrl_presc;
    w_rdata = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        TMR_MTIME_LO:    w_rdata = w_mtime[31:0];
        TMR_MTIME_HI:    w_rdata = w_mtime[63:32];
        TMR_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
        TMR_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
        TMR_CTRL:        w_rdata = w_ctrl_rd;
        default:         w_rdata = '0;
      endcase
    end
  end

  timer_counter #(
    .PRESC_W(PRESC_W)
  ) u_counter (
    .i_clk       (s_clk_i),
    .i_rst       (s_reset_i),
    .i_en        (r_ctrl_en),
    .i_presc     (r_ctrl_presc),
    .i_clr_presc (w_wr_ctrl),
    .i_wr_lo     (w_wr_mtime_lo),
    .i_wr_hi     (w_wr_mtime_hi),
    .i_wdata     (s_hwdata_i),
    .o_mtime     (w_mtime)
  );

  assign s_hrdata_o   = w_rdata;
  assign s_hready_o   = r_hready;
  assign s_hresp_o    = r_hresp;
  assign s_int_mtip_o = r_mtip;

endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboard bench for ahb_timer: pipelined AHB driver, read expectations queued at address phase.
module tb_ahb_timer;

  logic        s_clk_i = 1'b0;
  logic        s_reset_i;
  logic [4:0]  s_haddr_i;
  logic [31:0] s_hwdata_i;
  logic [2:0]  s_hsize_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic        s_hsel_i;
  logic [2:0]  s_hburst_i;
  logic [3:0]  s_hprot_i;
  logic        s_hmastlock_i;
  logic [31:0] s_hrdata_o;
  logic        s_hready_o;
  logic        s_hresp_o;
  logic        s_int_mtip_o;

  localparam logic [4:0] A_LO    = 5'h00;
  localparam logic [4:0] A_HI    = 5'h04;
  localparam logic [4:0] A_CMPLO = 5'h08;
  localparam logic [4:0] A_CMPHI = 5'h0C;
  localparam logic [4:0] A_CTRL  = 5'h10;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] sb_q[$];
  logic        pend_rd = 1'b0;
  logic        pend_any = 1'b0;
  logic [31:0] pend_wdata = '0;
  logic        dp_rd = 1'b0;
  logic        dp_any = 1'b0;

  ahb_timer #(.PRESC_W(8)) dut (
    .s_clk_i       (s_clk_i),
    .s_reset_i     (s_reset_i),
    .s_haddr_i     (s_haddr_i),
    .s_hwdata_i    (s_hwdata_i),
    .s_hsize_i     (s_hsize_i),
    .s_htrans_i    (s_htrans_i),
    .s_hwrite_i    (s_hwrite_i),
    .s_hsel_i      (s_hsel_i),
    .s_hburst_i    (s_hburst_i),
    .s_hprot_i     (s_hprot_i),
    .s_hmastlock_i (s_hmastlock_i),
    .s_hrdata_o    (s_hrdata_o),
    .s_hready_o    (s_hready_o),
    .s_hresp_o     (s_hresp_o),
    .s_int_mtip_o  (s_int_mtip_o)
  );

  always #5 s_clk_i = ~s_clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One address phase; the previous transfer's data phase runs in the same cycle.
  task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d);
    s_hsel_i   = 1'b1;
    s_htrans_i = 2'b10;
    s_haddr_i  = a;
    s_hwrite_i = wr;
    s_hsize_i  = 3'd2;
    s_hwdata_i = pend_wdata;
    dp_rd      = pend_rd;
    dp_any     = pend_any;
    if (!wr) sb_q.push_back(d);
    pend_rd    = !wr;
    pend_any   = 1'b1;
    pend_wdata = wr ? d : 32'h0;
    @(posedge s_clk_i); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    issue(1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    issue(1'b0, a, exp);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      s_hsel_i   = 1'b0;
      s_htrans_i = 2'b00;
      s_hwdata_i = pend_wdata;
      dp_rd      = pend_rd;
      dp_any     = pend_any;
      pend_rd    = 1'b0;
      pend_any   = 1'b0;
      pend_wdata = '0;
      @(posedge s_clk_i); #1;
    end
    dp_rd  = 1'b0;
    dp_any = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic rdy, input logic rsp);
    @(negedge s_clk_i);
    check_val({tag, "_hready"}, s_hready_o, rdy);
    check_val({tag, "_hresp"}, s_hresp_o, rsp);
    check_val({tag, "_hrdata"}, s_hrdata_o, 32'h0);
    @(posedge s_clk_i); #1;
  endtask

  always @(negedge s_clk_i) begin
    if (dp_any) begin
      check_val("dp_hready", s_hready_o, 1'b1);
      check_val("dp_hresp", s_hresp_o, 1'b0);
      if (!dp_rd) check_val("wr_dp_hrdata", s_hrdata_o, 32'h0);
    end
    if (dp_rd) begin
      check_val("sb_avail", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) check_val("rdata", s_hrdata_o, sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    s_reset_i = 1'b1;
    s_haddr_i = '0; s_hwdata_i = '0; s_hsize_i = 3'd2; s_htrans_i = 2'b00;
    s_hwrite_i = 1'b0; s_hsel_i = 1'b0;
    s_hburst_i = 3'b011; s_hprot_i = 4'b0011; s_hmastlock_i = 1'b1;
    repeat (2) @(posedge s_clk_i);
    @(negedge s_clk_i);
    check_val("rst_hready", s_hready_o, 1'b1);
    check_val("rst_hresp", s_hresp_o, 1'b0);
    check_val("rst_hrdata", s_hrdata_o, 32'h0);
    check_val("rst_mtip", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;
    s_reset_i = 1'b0;

    rd(A_CMPLO, 32'hFFFF_FFFF);
    rd(A_CMPHI, 32'hFFFF_FFFF);
    rd(A_LO, 32'h0);
    idle(1);
    @(negedge s_clk_i);
    check_val("mtip_after_reset", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;

    // PRESC=3: ticks land every 4th cycle; stopping it 40 cycles later leaves exactly 10.
    wr(A_CTRL, 32'h0000_0301);
    idle(39);
    wr(A_CTRL, 32'h0000_0300);
    rd(A_CTRL, 32'h0000_0300);
    rd(A_LO, 32'd10);
    rd(A_HI, 32'h0);
    idle(1);

    wr(A_CTRL, 32'hFFFF_FFFE);
    rd(A_CTRL, 32'h0000_FF00);
    wr(A_CTRL, 32'h0);
    idle(1);

    wr(A_LO, 32'hFFFF_FFFF);
    wr(A_HI, 32'h0);
    wr(A_CTRL, 32'h1);
    rd(A_LO, 32'hFFFF_FFFF);
    rd(A_LO, 32'h0);
    rd(A_HI, 32'h1);
    wr(A_CTRL, 32'h0);
    idle(1);

    wr(A_LO, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_CMPHI, 32'h0);
    wr(A_CMPLO, 32'd5);
    idle(1);
    @(negedge s_clk_i);
    check_val("mtip_below_cmp", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;
    wr(A_CTRL, 32'h1);
    idle(6);
    @(negedge s_clk_i);
    check_val("mtip_at_cmp_same_cycle", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;
    @(negedge s_clk_i);
    check_val("mtip_rise", s_int_mtip_o, 1'b1);
    @(posedge s_clk_i); #1;
    wr(A_CMPHI, 32'h1);
    idle(1);
    @(negedge s_clk_i);
    check_val("mtip_hold_after_cmp_wr", s_int_mtip_o, 1'b1);
    @(posedge s_clk_i); #1;
    @(negedge s_clk_i);
    check_val("mtip_fall", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;
    wr(A_CTRL, 32'h0);
    idle(1);

    // Byte write to 0x00 followed back-to-back by a word read of unmapped 0x14.
    wr(A_LO, 32'hAAAA_5555);
    wr(A_HI, 32'h0);
    idle(1);
    s_hsel_i = 1'b1; s_htrans_i = 2'b10; s_haddr_i = 5'h00; s_hwrite_i = 1'b1; s_hsize_i = 3'd0;
    @(posedge s_clk_i); #1;
    s_hwdata_i = 32'h1234_5678;
    s_haddr_i = 5'h14; s_hwrite_i = 1'b0; s_hsize_i = 3'd2;
    check_resp("err1_a", 1'b0, 1'b1);
    check_resp("err2_a", 1'b1, 1'b1);
    s_hsel_i = 1'b0; s_htrans_i = 2'b00; s_hwdata_i = '0;
    @(negedge s_clk_i);
    check_val("err1_b_hready", s_hready_o, 1'b0);
    check_val("err1_b_hresp", s_hresp_o, 1'b1);
    @(posedge s_clk_i); #1;
    check_resp("err2_b", 1'b1, 1'b1);
    check_resp("okay_after_err", 1'b1, 1'b0);
    rd(A_LO, 32'hAAAA_5555);
    rd(A_HI, 32'h0);
    idle(1);

    // MTIME_LO write lands on a tick that would carry into HI.
    wr(A_CTRL, 32'h0);
    wr(A_LO, 32'hFFFF_FFFF);
    wr(A_HI, 32'h7);
    wr(A_CTRL, 32'h1);
    wr(A_LO, 32'h0000_0100);
    rd(A_LO, 32'h0000_0100);
    rd(A_HI, 32'h7);
    wr(A_CTRL, 32'h0);
    idle(1);

    // Reset during the data phase of a MTIMECMP_LO write.
    wr(A_CMPLO, 32'h0000_1234);
    s_hsel_i = 1'b0; s_htrans_i = 2'b00; s_hwdata_i = 32'h0000_1234;
    pend_rd = 1'b0; pend_any = 1'b0; pend_wdata = '0;
    dp_rd = 1'b0; dp_any = 1'b0;
    #2 s_reset_i = 1'b1;
    @(negedge s_clk_i);
    check_val("midrst_hready", s_hready_o, 1'b1);
    check_val("midrst_hresp", s_hresp_o, 1'b0);
    check_val("midrst_mtip", s_int_mtip_o, 1'b0);
    @(posedge s_clk_i); #1;
    s_reset_i = 1'b0;
    rd(A_CMPLO, 32'hFFFF_FFFF);
    rd(A_LO, 32'h0);
    rd(A_CTRL, 32'h0);
    idle(2);

    check_val("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 The block SHALL have parameter PRESC_W, default 8, giving the width of the prescaler field and counter.
REQ-002 The block SHALL have the following ports, one per line:
  s_clk_i  in  1  single clock, rising edge
  s_reset_i  in  1  asynchronous, active-high reset
  s_haddr_i  in  5  AHB3-Lite byte address
  s_hwdata_i  in  32  write data, data phase
  s_hsize_i  in  3  transfer size
  s_htrans_i  in  2  transfer type
  s_hwrite_i  in  1  write/read
  s_hsel_i  in  1  slave select from ahb_interconnect
  s_hrdata_o  out  32  read data, data phase
  s_hready_o  out  1  transfer done
  s_hresp_o  out  1  1 = ERROR
  s_int_mtip_o  out  1  machine timer interrupt to hardisc s_int_mtip_i
REQ-003 s_hburst_i, s_hprot_i and s_hmastlock_i SHALL be accepted and ignored.

Function
REQ-004 An address phase SHALL be accepted when s_hsel_i & s_htrans_i[1] & s_hready_o; the address, write flag and size SHALL be registered for the data phase.
REQ-005 The register map SHALL be: 0x00 MTIME_LO; 0x04 MTIME_HI; 0x08 MTIMECMP_LO; 0x0C MTIMECMP_HI; 0x10 CTRL (bit0 EN, bits[8+PRESC_W-1:8] PRESC, others read 0). All registers are RW.
REQ-006 Valid accesses (word size, s_hsize_i=2, mapped address) SHALL complete with zero wait states: s_hready_o=1, s_hresp_o=0, write data captured at the end of the data phase, read data driven during the data phase.
REQ-007 Non-word size or unmapped address SHALL give a two-cycle ERROR: state ERR1 (s_hready_o=0, s_hresp_o=1), then ERR2 (s_hready_o=1, s_hresp_o=1), then OKAY; no register is modified.
REQ-008 Response FSM states SHALL be OKAY, ERR1, ERR2; OKAY->ERR1 on an accepted invalid access, ERR1->ERR2 unconditionally, ERR2->ERR1 if another invalid access is accepted in ERR2, else ERR2->OKAY.
REQ-009 While EN=1, the prescaler counter SHALL count 0..PRESC and, in the cycle it equals PRESC, clear and increment the 64-bit MTIME (wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0); PRESC=0 SHALL increment every cycle.
REQ-010 While EN=0, MTIME and the prescaler counter SHALL hold; a write to CTRL SHALL clear the prescaler counter.
REQ-011 A bus write to MTIME_LO or MTIME_HI in the same cycle as an increment SHALL win: the written half takes s_hwdata_i, the other half holds its pre-increment value.
REQ-012 s_int_mtip_o SHALL be registered as (MTIME >= MTIMECMP), unsigned 64-bit, one cycle after either operand changes.
REQ-013 s_hrdata_o SHALL be 0 outside a valid read data phase.

Reset
REQ-014 On s_reset_i high, asynchronously: MTIME=0, MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, CTRL=0, prescaler counter=0, FSM=OKAY, data-phase registers cleared.
REQ-015 Reset output values SHALL be s_hready_o=1, s_hresp_o=0, s_hrdata_o=0, s_int_mtip_o=0.
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer; no write is committed.

Structure
REQ-017 Register offsets, CTRL bit positions and the response FSM state enum SHALL live in p_hardisc.
REQ-018 The 64-bit counter with prescaler SHALL be one sub-module, timer_counter; the AHB decode, FSM and compare stay in ahb_timer.

Verification
REQ-019 Reset, then read MTIMECMP_LO -> 0xFFFFFFFF, OKAY, zero wait; s_int_mtip_o=0.
REQ-020 Write CTRL=0x0301 (EN, PRESC=3) -> MTIME_LO increments once per 4 cycles; read after 40 cycles = 10 (±1 for write/read latency).
REQ-021 MTIME=0x0000_0000_FFFF_FFFF, PRESC=0, EN=1 -> next cycle MTIME_HI=1, MTIME_LO=0.
REQ-022 MTIMECMP=5, MTIME=0, EN=1, PRESC=0 -> s_int_mtip_o rises 1 cycle after MTIME reaches 5; writing MTIMECMP_HI=1 drops it 1 cycle later.
REQ-023 Byte write (hsize=0) to 0x00, then back-to-back word read to 0x14 -> ERR1, ERR2, ERR1, ERR2; MTIME unchanged.
REQ-024 Write MTIME_LO=0x100 in an increment cycle -> MTIME_LO reads 0x100 immediately after; reset asserted during a write data phase -> register keeps reset value.
